// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The MEM stage drives the request side; memory answers with a one-cycle ack pulse.
interface mem_stage_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage responder: runs loads/stores over the data-memory handshake, stalls the
// upstream pipeline while an access is outstanding, and drives the MEM/WB fields.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        M_i,
  input  logic [31:0]       DMaddr_i,
  input  logic [31:0]       DMdata_i,
  input  logic [4:0]        RDaddr_i,
  output logic              stall_o,
  mem_stage_ctrl_if.master  mem,
  output logic [1:0]        WB_o,
  output logic [31:0]       RDdata_o,
  output logic [31:0]       ALUres_o,
  output logic [4:0]        RDaddr_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       wb_h_q, wb_h_d;
  logic [4:0]       rd_h_q, rd_h_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       wb_o_q, wb_o_d;
  logic [31:0]      rddata_q, rddata_d;
  logic [31:0]      alures_q, alures_d;
  logic [4:0]       rdaddr_q, rdaddr_d;
  logic             err_q, err_d;

  logic is_ls, acc, tmo;

  assign is_ls = (M_i == 2'b10) || (M_i == 2'b01);
  assign acc   = is_ls && (DMaddr_i[1:0] == 2'b00);
  assign tmo   = (count_q == TMO_CNT);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wb_h_d   = wb_h_q;
    rd_h_d   = rd_h_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    wb_o_d   = wb_o_q;
    rddata_d = rddata_q;
    alures_d = alures_q;
    rdaddr_d = rdaddr_q;
    err_d    = err_q;
    stall_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_o = acc;
        if (M_i == 2'b00) begin
          wb_o_d   = WB_i;
          alures_d = DMaddr_i;
          rdaddr_d = RDaddr_i;
          rddata_d = '0;
        end else if (!acc) begin
          // Illegal op or misaligned address: flag it and send a bubble to writeback.
          err_d    = 1'b1;
          wb_o_d   = 2'b00;
          alures_d = DMaddr_i;
          rdaddr_d = RDaddr_i;
          rddata_d = '0;
        end else begin
          state_d = ACCESS;
          count_d = '0;
          wb_h_d  = WB_i;
          rd_h_d  = RDaddr_i;
          req_d   = 1'b1;
          we_d    = M_i[0];
          maddr_d = DMaddr_i;
          wdata_d = DMdata_i;
          wb_o_d  = 2'b00;
        end
      end

      ACCESS: begin
        // The request address register doubles as the held ALU result.
        stall_o = !mem.mem_ack_i && !tmo;
        if (mem.mem_ack_i || tmo) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          alures_d = maddr_q;
          rdaddr_d = rd_h_q;
          if (mem.mem_ack_i) begin
            wb_o_d   = wb_h_q;
            rddata_d = we_q ? 32'h0 : mem.mem_rdata_i;
          end else begin
            wb_o_d   = {1'b0, wb_h_q[0]};
            rddata_d = '0;
            err_d    = 1'b1;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wb_h_q   <= '0;
      rd_h_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      wb_o_q   <= '0;
      rddata_q <= '0;
      alures_q <= '0;
      rdaddr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wb_h_q   <= wb_h_d;
      rd_h_q   <= rd_h_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      wb_o_q   <= wb_o_d;
      rddata_q <= rddata_d;
      alures_q <= alures_d;
      rdaddr_q <= rdaddr_d;
      err_q    <= err_d;
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = maddr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign WB_o            = wb_o_q;
  assign RDdata_o        = rddata_q;
  assign ALUres_o        = alures_q;
  assign RDaddr_o        = rdaddr_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, hand-written timeout/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_stage_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_i, m_i;
  logic [31:0] dmaddr, dmdata;
  logic [4:0]  rdaddr_i;
  logic        stall;
  logic [1:0]  wb_o;
  logic [31:0] rddata_o, alures_o;
  logic [4:0]  rdaddr_o;
  logic        err;

  always #5 clk = ~clk;

  mem_stage_ctrl_if mem_if ();

  mem_stage_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .WB_i     (wb_i),
    .M_i      (m_i),
    .DMaddr_i (dmaddr),
    .DMdata_i (dmdata),
    .RDaddr_i (rdaddr_i),
    .stall_o  (stall),
    .mem      (mem_if),
    .WB_o     (wb_o),
    .RDdata_o (rddata_o),
    .ALUres_o (alures_o),
    .RDaddr_o (rdaddr_o),
    .err_o    (err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] wb, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic ack, input logic [31:0] rdat);
    @(negedge clk);
    rst      = r;
    wb_i     = wb;
    m_i      = m;
    dmaddr   = a;
    dmdata   = d;
    rdaddr_i = rd;
    mem_if.mem_ack_i   = ack;
    mem_if.mem_rdata_i = rdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        ack;
    logic [31:0] rdat;
    logic        x_stall;
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [1:0]  x_wb;
    logic [31:0] x_rddata;
    logic [31:0] x_alu;
    logic [4:0]  x_rd;
    logic        x_err;
    logic        x_chk;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  // Reference model: one outstanding transaction plus the visible MEM/WB fields.
  bit          mb_busy;
  bit          mb_load;
  int          mb_cyc;
  logic [1:0]  mb_wb;
  logic [4:0]  mb_rd;
  logic        e_req, e_we, e_err, e_known;
  logic [31:0] e_addr, e_wdata, e_rddata, e_alu;
  logic [1:0]  e_wb;
  logic [4:0]  e_rd;

  function automatic logic model_stall(input logic [1:0] m, input logic [31:0] a, input logic ack);
    if (!mb_busy) return ((m == 2'b10) || (m == 2'b01)) && (a[1:0] == 2'b00);
    return !(ack || (mb_cyc == TO));
  endfunction

  task automatic model_step(input logic r, input logic [1:0] wb, input logic [1:0] m,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                            input logic ack, input logic [31:0] rdat);
    if (r) begin
      mb_busy = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wb = 0;
      e_rddata = 0; e_alu = 0; e_rd = 0; e_err = 0; e_known = 1;
    end else if (!mb_busy) begin
      if (m == 2'b00) begin
        e_wb = wb; e_alu = a; e_rd = rd; e_rddata = 0; e_known = 1;
      end else if (m == 2'b11 || a[1:0] != 2'b00) begin
        e_err = 1; e_wb = 0; e_alu = a; e_rd = rd; e_rddata = 0; e_known = 1;
      end else begin
        mb_busy = 1; mb_cyc = 1; mb_load = (m == 2'b10); mb_wb = wb; mb_rd = rd;
        e_req = 1; e_we = !mb_load; e_addr = a; e_wdata = d; e_wb = 0; e_known = 0;
      end
    end else if (ack || mb_cyc == TO) begin
      mb_busy = 0; e_req = 0; e_alu = e_addr; e_rd = mb_rd; e_known = 1;
      if (ack) begin
        e_wb = mb_wb; e_rddata = mb_load ? rdat : 32'h0;
      end else begin
        e_wb = {1'b0, mb_wb[0]}; e_rddata = 0; e_err = 1;
      end
    end else begin
      mb_cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int stalls;
    int ack_pct;
    logic        r, ack;
    logic [1:0]  wb, m;
    logic [31:0] a, d, rdat;
    logic [4:0]  rd;
    int          sel;

    tbl[0]  = '{1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 2'b10, 2'b00, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h0, 32'h1234, 5'd5, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 2'b11, 2'b10, 32'h40, 32'h0, 5'd7, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 2'b01, 32'h99, 32'h77, 5'd1, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 2'b11, 32'h44, 32'h66, 5'd2, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 32'h13, 32'h0, 5'd2, 1'b1, 32'hDEADBEEF,
                1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 2'b11, 32'hDEADBEEF, 32'h40, 5'd7, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'b01, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 32'h12345678,
                1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 2'b01, 32'h0, 32'h80, 5'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'b11, 2'b10, 32'h42, 32'h0, 5'd9, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 2'b00, 32'h0, 32'h42, 5'd9, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'b10, 2'b11, 32'h100, 32'h0, 5'd4, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h100, 5'd4, 1'b1, 1'b1};
    tbl[11] = tbl[9];
    tbl[12] = '{1'b0, 2'b11, 2'b00, 32'hCAFE0000, 32'h0, 5'd31, 1'b1, 32'h5,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 32'h0, 32'hCAFE0000, 5'd31, 1'b0, 1'b1};

    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].wb, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].ack, tbl[i].rdat);
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].x_stall));
      tick();
      chk($sformatf("tbl%0d_req", i), 32'(mem_if.mem_req_o), 32'(tbl[i].x_req));
      chk($sformatf("tbl%0d_we", i), 32'(mem_if.mem_we_o), 32'(tbl[i].x_we));
      chk($sformatf("tbl%0d_addr", i), mem_if.mem_addr_o, tbl[i].x_addr);
      chk($sformatf("tbl%0d_wdata", i), mem_if.mem_wdata_o, tbl[i].x_wdata);
      chk($sformatf("tbl%0d_wb", i), 32'(wb_o), 32'(tbl[i].x_wb));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].x_err));
      if (tbl[i].x_chk) begin
        chk($sformatf("tbl%0d_rddata", i), rddata_o, tbl[i].x_rddata);
        chk($sformatf("tbl%0d_alu", i), alures_o, tbl[i].x_alu);
        chk($sformatf("tbl%0d_rd", i), 32'(rdaddr_o), 32'(tbl[i].x_rd));
      end
    end

    // Load that never gets an ack: stall for TO cycles, then forced completion.
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) drive(1'b0, 2'b11, 2'b10, 32'h200, 32'h0, 5'd6, 1'b0, 32'h0);
      else        drive(1'b0, 2'b00, 2'b00, 32'h4, 32'h0, 5'd1, 1'b0, 32'h0);
      if (!stall) begin
        tick();
        break;
      end
      stalls++;
      tick();
    end
    chk("tmo_stall_cycles", 32'(stalls), 32'(TO));
    chk("tmo_req", 32'(mem_if.mem_req_o), 32'h0);
    chk("tmo_wb", 32'(wb_o), 32'h1);
    chk("tmo_rddata", rddata_o, 32'h0);
    chk("tmo_alu", alures_o, 32'h200);
    chk("tmo_rd", 32'(rdaddr_o), 32'd6);
    chk("tmo_err", 32'(err), 32'h1);

    // Late ack after the timeout lands in IDLE and must be ignored.
    drive(1'b0, 2'b10, 2'b00, 32'h8, 32'h0, 5'd2, 1'b1, 32'hFFFFFFFF);
    chk("late_ack_stall", 32'(stall), 32'h0);
    tick();
    chk("late_ack_wb", 32'(wb_o), 32'h2);
    chk("late_ack_rddata", rddata_o, 32'h0);
    chk("late_ack_req", 32'(mem_if.mem_req_o), 32'h0);
    chk("late_ack_alu", alures_o, 32'h8);
    chk("late_ack_err", 32'(err), 32'h1);

    // Reset in the middle of an access, then an ALU op right after.
    drive(1'b0, 2'b11, 2'b10, 32'h300, 32'h0, 5'd12, 1'b0, 32'h0);
    tick();
    chk("mid_rst_req_before", 32'(mem_if.mem_req_o), 32'h1);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    chk("mid_rst_req", 32'(mem_if.mem_req_o), 32'h0);
    chk("mid_rst_we", 32'(mem_if.mem_we_o), 32'h0);
    chk("mid_rst_addr", mem_if.mem_addr_o, 32'h0);
    chk("mid_rst_wb", 32'(wb_o), 32'h0);
    chk("mid_rst_rddata", rddata_o, 32'h0);
    chk("mid_rst_alu", alures_o, 32'h0);
    chk("mid_rst_rd", 32'(rdaddr_o), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    drive(1'b0, 2'b10, 2'b00, 32'h55, 32'h0, 5'd8, 1'b0, 32'h0);
    chk("post_rst_stall", 32'(stall), 32'h0);
    tick();
    chk("post_rst_wb", 32'(wb_o), 32'h2);
    chk("post_rst_alu", alures_o, 32'h55);
    chk("post_rst_rd", 32'(rdaddr_o), 32'd8);
    chk("post_rst_req", 32'(mem_if.mem_req_o), 32'h0);

    // Randomized traffic against the reference model.
    ack_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        sel = $urandom_range(0, 3);
        ack_pct = (sel == 0) ? 0 : (sel == 1) ? 10 : (sel == 2) ? 40 : 90;
      end
      r = (i == 0) || ($urandom_range(0, 99) < 2);
      sel = $urandom_range(0, 9);
      m = (sel < 4) ? 2'b00 : (sel < 6) ? 2'b10 : (sel < 9) ? 2'b01 : 2'b11;
      wb = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      d = $urandom;
      rd = 5'($urandom_range(0, 31));
      ack = ($urandom_range(0, 99) < ack_pct);
      rdat = $urandom;

      drive(r, wb, m, a, d, rd, ack, rdat);
      chk("rnd_stall", 32'(stall), 32'(model_stall(m, a, ack)));
      model_step(r, wb, m, a, d, rd, ack, rdat);
      tick();
      chk("rnd_req", 32'(mem_if.mem_req_o), 32'(e_req));
      chk("rnd_we", 32'(mem_if.mem_we_o), 32'(e_we));
      chk("rnd_addr", mem_if.mem_addr_o, e_addr);
      chk("rnd_wdata", mem_if.mem_wdata_o, e_wdata);
      chk("rnd_wb", 32'(wb_o), 32'(e_wb));
      chk("rnd_err", 32'(err), 32'(e_err));
      if (e_known) begin
        chk("rnd_rddata", rddata_o, e_rddata);
        chk("rnd_alu", alures_o, e_alu);
        chk("rnd_rd", 32'(rdaddr_o), 32'(e_rd));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
